// File: rtl/pio_shift_unit.sv
// pio_shift_unit: ISR/OSR shifters with bit counters, autopush/autopull
// thresholds and blocking RX/TX FIFO handshakes for one PIO state machine.
module pio_shift_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic             in_dir,
    input  logic             out_dir,
    input  logic             auto_push,
    input  logic             auto_pull,
    input  logic [CNT_W-1:0] push_thresh,
    input  logic [CNT_W-1:0] pull_thresh,
    input  logic             in_req,
    input  logic [CNT_W-1:0] in_count,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_req,
    input  logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] out_data,
    input  logic             push_req,
    input  logic             push_iffull,
    input  logic             push_block,
    input  logic             pull_req,
    input  logic             pull_ifempty,
    input  logic             pull_block,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_push,
    input  logic             rx_full,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_pull,
    input  logic             tx_empty,
    output logic [WIDTH-1:0] isr,
    output logic [WIDTH-1:0] osr,
    output logic [CNT_W-1:0] isr_count,
    output logic [CNT_W-1:0] osr_count,
    output logic             stall,
    output logic             done
);
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] PUSH_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    // A count or threshold of zero stands for a full register.
    function automatic logic [CNT_W-1:0] decode(
        input logic [CNT_W-1:0] v
    );
        return (v == '0 || v > FULL) ? FULL : v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, FULL}) ? FULL : s[CNT_W-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] low_mask(
        input logic [CNT_W-1:0] n
    );
        return ONES >> (FULL - n);
    endfunction

    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic [WIDTH-1:0] isr_nx;
    logic [WIDTH-1:0] osr_nx;
    logic [CNT_W-1:0] isr_count_nx;
    logic [CNT_W-1:0] osr_count_nx;

    logic [CNT_W-1:0] in_n;
    logic [CNT_W-1:0] out_n;
    logic [CNT_W-1:0] push_th;
    logic [CNT_W-1:0] pull_th;
    logic [CNT_W-1:0] in_cnt_new;
    logic [CNT_W-1:0] out_base;
    logic [WIDTH-1:0] in_shift;
    logic [WIDTH-1:0] out_src;
    logic [WIDTH-1:0] out_bits;
    logic [WIDTH-1:0] out_shift;
    logic             exhausted;

    assign in_n       = decode(in_count);
    assign out_n      = decode(out_count);
    assign push_th    = decode(push_thresh);
    assign pull_th    = decode(pull_thresh);
    assign in_cnt_new = sat_add(isr_count, in_n);

    always_comb begin
        if (in_n == FULL) begin
            in_shift = in_data;
        end else if (in_dir) begin
            in_shift = (isr >> in_n) | (in_data << (FULL - in_n));
        end else begin
            in_shift = (isr << in_n) | (in_data & low_mask(in_n));
        end
    end

    // An exhausted OSR is refilled from the TX head within the same OUT.
    assign exhausted = auto_pull && (osr_count >= pull_th);
    assign out_src   = exhausted ? tx_data : osr;
    assign out_base  = exhausted ? '0 : osr_count;

    always_comb begin
        if (out_n == FULL) begin
            out_bits  = out_src;
            out_shift = '0;
        end else if (out_dir) begin
            out_bits  = out_src & low_mask(out_n);
            out_shift = out_src >> out_n;
        end else begin
            out_bits  = out_src >> (FULL - out_n);
            out_shift = out_src << out_n;
        end
    end

    assign out_data = (state == IDLE && !in_req && out_req) ? out_bits : '0;

    always_comb begin
        state_nx     = state;
        isr_nx       = isr;
        isr_count_nx = isr_count;
        osr_nx       = osr;
        osr_count_nx = osr_count;
        rx_push      = 1'b0;
        rx_data      = isr;
        tx_pull      = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        if (penable) begin
            if (state == PUSH_WAIT) begin
                if (!rx_full) begin
                    rx_push      = 1'b1;
                    isr_nx       = '0;
                    isr_count_nx = '0;
                    done         = 1'b1;
                    state_nx     = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end else if (in_req) begin
                isr_nx       = in_shift;
                isr_count_nx = in_cnt_new;
                if (auto_push && in_cnt_new >= push_th) begin
                    if (!rx_full) begin
                        rx_push      = 1'b1;
                        rx_data      = in_shift;
                        isr_nx       = '0;
                        isr_count_nx = '0;
                        done         = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        state_nx = PUSH_WAIT;
                    end
                end else begin
                    done = 1'b1;
                end
            end else if (out_req) begin
                if (exhausted && tx_empty) begin
                    stall = 1'b1;
                end else begin
                    tx_pull      = exhausted;
                    osr_nx       = out_shift;
                    osr_count_nx = sat_add(out_base, out_n);
                    done         = 1'b1;
                end
            end else if (push_req) begin
                if (push_iffull && isr_count < push_th) begin
                    done = 1'b1;
                end else if (!rx_full) begin
                    rx_push      = 1'b1;
                    isr_nx       = '0;
                    isr_count_nx = '0;
                    done         = 1'b1;
                end else if (push_block) begin
                    stall = 1'b1;
                end else begin
                    isr_nx       = '0;
                    isr_count_nx = '0;
                    done         = 1'b1;
                end
            end else if (pull_req) begin
                if (pull_ifempty && osr_count < pull_th) begin
                    done = 1'b1;
                end else if (!tx_empty) begin
                    tx_pull      = 1'b1;
                    osr_nx       = tx_data;
                    osr_count_nx = '0;
                    done         = 1'b1;
                end else if (pull_block) begin
                    stall = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            isr       <= '0;
            isr_count <= '0;
            osr       <= '0;
            osr_count <= FULL;
        end else begin
            state     <= state_nx;
            isr       <= isr_nx;
            isr_count <= isr_count_nx;
            osr       <= osr_nx;
            osr_count <= osr_count_nx;
        end
    end
endmodule

// File: tb/tb_pio_shift_unit.sv
// tb_pio_shift_unit: directed vectors, a behavioural model checked on
// every falling edge, and hand-computed pins for key cycles.
module tb_pio_shift_unit;
    localparam int W  = 32;
    localparam int CW = 6;
    localparam int NP = 10;
    localparam int P_ISR   = 0;
    localparam int P_IC    = 1;
    localparam int P_OSR   = 2;
    localparam int P_OC    = 3;
    localparam int P_OUT   = 4;
    localparam int P_RXD   = 5;
    localparam int P_RXP   = 6;
    localparam int P_TXP   = 7;
    localparam int P_STALL = 8;
    localparam int P_DONE  = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, penable, in_dir, out_dir;
    logic          auto_push, auto_pull;
    logic [CW-1:0] push_thresh, pull_thresh;
    logic [CW-1:0] in_count, out_count;
    logic          in_req, out_req;
    logic [W-1:0]  in_data, out_data, rx_data, tx_data;
    logic          push_req, push_iffull, push_block;
    logic          pull_req, pull_ifempty, pull_block;
    logic          rx_push, rx_full, tx_pull, tx_empty;
    logic [W-1:0]  isr, osr;
    logic [CW-1:0] isr_count, osr_count;
    logic          stall, done;

    pio_shift_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .penable(penable),
        .in_dir(in_dir), .out_dir(out_dir),
        .auto_push(auto_push), .auto_pull(auto_pull),
        .push_thresh(push_thresh), .pull_thresh(pull_thresh),
        .in_req(in_req), .in_count(in_count), .in_data(in_data),
        .out_req(out_req), .out_count(out_count),
        .out_data(out_data),
        .push_req(push_req), .push_iffull(push_iffull),
        .push_block(push_block),
        .pull_req(pull_req), .pull_ifempty(pull_ifempty),
        .pull_block(pull_block),
        .rx_data(rx_data), .rx_push(rx_push), .rx_full(rx_full),
        .tx_data(tx_data), .tx_pull(tx_pull), .tx_empty(tx_empty),
        .isr(isr), .osr(osr),
        .isr_count(isr_count), .osr_count(osr_count),
        .stall(stall), .done(done)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] m_isr = '0;
    logic [63:0] m_osr = '0;
    int          m_ic = 0;
    int          m_oc = W;
    bit          m_wait = 0;
    bit          armed = 0;

    bit          pin_on [NP];
    logic [31:0] pin_exp [NP];

    function automatic int dec(input logic [CW-1:0] v);
        return (v == '0) ? W : int'(v);
    endfunction

    function automatic logic [63:0] msk(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic int sat(input int v);
        return (v > W) ? W : v;
    endfunction

    function automatic string pin_name(input int s);
        case (s)
            P_ISR:   return "pin_isr";
            P_IC:    return "pin_isr_count";
            P_OSR:   return "pin_osr";
            P_OC:    return "pin_osr_count";
            P_OUT:   return "pin_out_data";
            P_RXD:   return "pin_rx_data";
            P_RXP:   return "pin_rx_push";
            P_TXP:   return "pin_tx_pull";
            P_STALL: return "pin_stall";
            default: return "pin_done";
        endcase
    endfunction

    function automatic logic [31:0] probe(input int s);
        case (s)
            P_ISR:   return isr;
            P_IC:    return 32'(isr_count);
            P_OSR:   return osr;
            P_OC:    return 32'(osr_count);
            P_OUT:   return out_data;
            P_RXD:   return rx_data;
            P_RXP:   return 32'(rx_push);
            P_TXP:   return 32'(tx_pull);
            P_STALL: return 32'(stall);
            default: return 32'(done);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h want %h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [63:0] n_isr, n_osr, src, val;
        logic [31:0] e_rx, e_out;
        int          n_ic, n_oc, n, base;
        bit          n_wait, e_push, e_pull, e_stall, e_done;
        bit          ex, chk_out;
        n_isr = m_isr; n_osr = m_osr;
        n_ic = m_ic; n_oc = m_oc; n_wait = m_wait;
        e_push = 0; e_pull = 0; e_stall = 0; e_done = 0;
        e_rx = '0; e_out = '0; chk_out = 0;
        chk("one_request",
            32'($countones({in_req, out_req, push_req, pull_req}) <= 1),
            32'd1);
        if (armed) begin
            chk("isr", isr, m_isr[31:0]);
            chk("isr_count", 32'(isr_count), 32'(m_ic));
            chk("osr", osr, m_osr[31:0]);
            chk("osr_count", 32'(osr_count), 32'(m_oc));
        end
        if (reset) begin
            n_isr = '0; n_ic = 0; n_osr = '0; n_oc = W; n_wait = 0;
        end else if (penable) begin
            if (m_wait) begin
                if (!rx_full) begin
                    e_push = 1; e_rx = m_isr[31:0]; e_done = 1;
                    n_isr = '0; n_ic = 0; n_wait = 0;
                end else begin
                    e_stall = 1;
                end
            end else if (in_req) begin
                n = dec(in_count);
                if (in_dir)
                    val = (m_isr >> n) | ((in_data & msk(n)) << (W - n));
                else
                    val = (m_isr << n) | (in_data & msk(n));
                val = val & msk(W);
                n_isr = val;
                n_ic = sat(m_ic + n);
                if (auto_push && n_ic >= dec(push_thresh)) begin
                    if (!rx_full) begin
                        e_push = 1; e_rx = val[31:0]; e_done = 1;
                        n_isr = '0; n_ic = 0;
                    end else begin
                        e_stall = 1; n_wait = 1;
                    end
                end else begin
                    e_done = 1;
                end
            end else if (out_req) begin
                n = dec(out_count);
                ex = auto_pull && (m_oc >= dec(pull_thresh));
                if (ex && tx_empty) begin
                    e_stall = 1;
                end else begin
                    src = ex ? {32'b0, tx_data} : m_osr;
                    base = ex ? 0 : m_oc;
                    if (out_dir) begin
                        e_out = 32'(src & msk(n));
                        n_osr = src >> n;
                    end else begin
                        e_out = 32'(src >> (W - n));
                        n_osr = (src << n) & msk(W);
                    end
                    n_oc = sat(base + n);
                    e_pull = ex; e_done = 1; chk_out = 1;
                end
            end else if (push_req) begin
                if (push_iffull && m_ic < dec(push_thresh)) begin
                    e_done = 1;
                end else if (!rx_full) begin
                    e_push = 1; e_rx = m_isr[31:0]; e_done = 1;
                    n_isr = '0; n_ic = 0;
                end else if (push_block) begin
                    e_stall = 1;
                end else begin
                    e_done = 1; n_isr = '0; n_ic = 0;
                end
            end else if (pull_req) begin
                if (pull_ifempty && m_oc < dec(pull_thresh)) begin
                    e_done = 1;
                end else if (!tx_empty) begin
                    e_pull = 1; e_done = 1;
                    n_osr = {32'b0, tx_data}; n_oc = 0;
                end else if (pull_block) begin
                    e_stall = 1;
                end else begin
                    e_done = 1;
                end
            end
        end
        if (!reset && armed) begin
            chk("rx_push", 32'(rx_push), 32'(e_push));
            chk("tx_pull", 32'(tx_pull), 32'(e_pull));
            chk("stall", 32'(stall), 32'(e_stall));
            chk("done", 32'(done), 32'(e_done));
            if (e_push) chk("rx_data", rx_data, e_rx);
            if (chk_out) chk("out_data", out_data, e_out);
        end
        for (int i = 0; i < NP; i++)
            if (pin_on[i]) chk(pin_name(i), probe(i), pin_exp[i]);
        if (reset) armed = 1;
        m_isr = n_isr; m_osr = n_osr;
        m_ic = n_ic; m_oc = n_oc; m_wait = n_wait;
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) pin_on[i] = 0;
    endtask

    task automatic pin(input int s, input logic [31:0] v);
        pin_on[s] = 1;
        pin_exp[s] = v;
    endtask

    task automatic idle_reqs();
        in_req = 0; out_req = 0; push_req = 0; pull_req = 0;
    endtask

    task automatic do_reset();
        idle_reqs();
        reset = 1;
        step();
        reset = 0;
    endtask

    logic [31:0] pe_out [3] = '{32'hBE, 32'hAD, 32'hDE};

    initial begin
        reset = 1; penable = 1; in_dir = 0; out_dir = 0;
        auto_push = 0; auto_pull = 0;
        push_thresh = '0; pull_thresh = '0;
        in_req = 0; in_count = '0; in_data = '0;
        out_req = 0; out_count = '0;
        push_req = 0; push_iffull = 0; push_block = 0;
        pull_req = 0; pull_ifempty = 0; pull_block = 0;
        rx_full = 0; tx_data = '0; tx_empty = 1;
        step(); step();
        reset = 0;
        pin(P_ISR, 0); pin(P_IC, 0); pin(P_OSR, 0); pin(P_OC, 32);
        pin(P_STALL, 0); pin(P_DONE, 0);
        step();

        // three left INs of 8 bits
        in_req = 1; in_count = 6'd8; in_data = 32'hAA;
        pin(P_DONE, 1); pin(P_RXP, 0);
        step();
        in_data = 32'hBB; step();
        in_data = 32'hCC; step();
        idle_reqs();
        pin(P_ISR, 32'h00AABBCC); pin(P_IC, 24); pin(P_RXP, 0);
        step();

        // autopush at 16 bits, RX has room
        do_reset();
        auto_push = 1; push_thresh = 6'd16;
        in_req = 1; in_data = 32'h12; step();
        in_data = 32'h34;
        pin(P_RXP, 1); pin(P_RXD, 32'h1234); pin(P_DONE, 1);
        step();
        idle_reqs();
        pin(P_ISR, 0); pin(P_IC, 0);
        step();

        // autopush with RX full: wait, then drain
        rx_full = 1;
        in_req = 1; in_data = 32'h12; step();
        in_data = 32'h34;
        pin(P_STALL, 1); pin(P_DONE, 0); pin(P_RXP, 0);
        step();
        in_data = 32'h99;
        for (int k = 0; k < 3; k++) begin
            pin(P_STALL, 1); pin(P_RXP, 0); pin(P_DONE, 0);
            step();
        end
        rx_full = 0;
        pin(P_RXP, 1); pin(P_RXD, 32'h1234); pin(P_DONE, 1);
        step();
        idle_reqs();
        pin(P_ISR, 0); pin(P_IC, 0); pin(P_STALL, 0);
        step();

        // reset while in PUSH_WAIT
        rx_full = 1;
        in_req = 1; in_data = 32'h12; step();
        in_data = 32'h34; step();
        idle_reqs();
        pin(P_STALL, 1);
        step();
        reset = 1; step();
        reset = 0; rx_full = 0;
        pin(P_RXP, 0); pin(P_STALL, 0); pin(P_ISR, 0); pin(P_IC, 0);
        step();
        auto_push = 0;

        // autopull, right shift
        do_reset();
        auto_pull = 1; pull_thresh = '0; out_dir = 1;
        tx_data = 32'hDEADBEEF; tx_empty = 0;
        out_req = 1; out_count = 6'd8;
        pin(P_TXP, 1); pin(P_OUT, 32'hEF); pin(P_DONE, 1);
        step();
        tx_empty = 1;
        pin(P_OSR, 32'h00DEADBE); pin(P_OC, 8);
        pin(P_OUT, 32'hBE); pin(P_TXP, 0);
        step();
        pin(P_OUT, 32'hAD); step();
        pin(P_OUT, 32'hDE); pin(P_OC, 24); step();
        pin(P_STALL, 1); pin(P_DONE, 0); pin(P_OC, 32); pin(P_OSR, 0);
        step();
        pin(P_STALL, 1); pin(P_TXP, 0); step();
        tx_empty = 0; tx_data = 32'h11223344;
        pin(P_TXP, 1); pin(P_OUT, 32'h44); pin(P_DONE, 1);
        step();
        idle_reqs(); tx_empty = 1;
        pin(P_OSR, 32'h00112233); pin(P_OC, 8);
        step();

        // explicit PULL variants
        auto_pull = 0;
        pull_req = 1; pull_ifempty = 0; pull_block = 0;
        pin(P_DONE, 1); pin(P_TXP, 0); pin(P_STALL, 0);
        step();
        pull_block = 1;
        pin(P_STALL, 1); pin(P_OSR, 32'h00112233); pin(P_OC, 8);
        step();
        tx_empty = 0; tx_data = 32'hCAFEF00D;
        pin(P_TXP, 1); pin(P_DONE, 1);
        step();
        idle_reqs();
        pin(P_OSR, 32'hCAFEF00D); pin(P_OC, 0);
        step();
        pull_req = 1; pull_ifempty = 1; tx_data = 32'h5555AAAA;
        pin(P_TXP, 0); pin(P_DONE, 1);
        step();
        idle_reqs(); tx_empty = 1; pull_ifempty = 0; pull_block = 0;
        pin(P_OSR, 32'hCAFEF00D);
        step();

        // explicit PUSH variants
        in_dir = 0;
        in_req = 1; in_count = 6'd4; in_data = 32'h5; step();
        idle_reqs();
        push_req = 1; push_iffull = 1; push_thresh = 6'd8;
        pin(P_DONE, 1); pin(P_RXP, 0); pin(P_IC, 4); pin(P_ISR, 5);
        step();
        push_iffull = 0; rx_full = 1; push_block = 1;
        pin(P_STALL, 1); pin(P_DONE, 0); pin(P_RXP, 0);
        step();
        rx_full = 0;
        pin(P_RXP, 1); pin(P_RXD, 5); pin(P_DONE, 1);
        step();
        idle_reqs();
        pin(P_ISR, 0); pin(P_IC, 0);
        step();
        in_req = 1; in_data = 32'hA; step();
        idle_reqs();
        push_req = 1; push_block = 0; rx_full = 1;
        pin(P_RXP, 0); pin(P_DONE, 1); pin(P_ISR, 32'hA);
        step();
        idle_reqs(); rx_full = 0;
        pin(P_ISR, 0); pin(P_IC, 0);
        step();

        // full-width boundaries
        in_dir = 1;
        in_req = 1; in_count = '0; in_data = 32'h89ABCDEF; step();
        in_count = 6'd4; in_data = 32'hF;
        pin(P_ISR, 32'h89ABCDEF); pin(P_IC, 32);
        step();
        idle_reqs();
        pin(P_ISR, 32'hF89ABCDE); pin(P_IC, 32);
        step();
        out_dir = 0;
        out_req = 1; out_count = 6'd4;
        pin(P_OUT, 32'hC);
        step();
        out_count = '0;
        pin(P_OSR, 32'hAFEF00D0); pin(P_OC, 4); pin(P_OUT, 32'hAFEF00D0);
        step();
        idle_reqs();
        pin(P_OSR, 0); pin(P_OC, 32);
        step();

        // autopull with penable high one cycle in three
        do_reset();
        auto_pull = 1; pull_thresh = '0; out_dir = 1;
        tx_data = 32'hDEADBEEF; tx_empty = 0;
        out_req = 1; out_count = 6'd8;
        penable = 0; step(); step();
        penable = 1;
        pin(P_TXP, 1); pin(P_OUT, 32'hEF);
        step();
        tx_empty = 1;
        for (int k = 0; k < 3; k++) begin
            penable = 0;
            pin(P_TXP, 0); pin(P_DONE, 0);
            step();
            step();
            penable = 1;
            pin(P_OUT, pe_out[k]); pin(P_TXP, 0); pin(P_DONE, 1);
            step();
        end
        penable = 0;
        pin(P_STALL, 0); pin(P_OC, 32);
        step(); step();
        penable = 1;
        pin(P_STALL, 1); pin(P_DONE, 0);
        step();
        idle_reqs();
        pin(P_OSR, 0); pin(P_OC, 32);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pio_shift_unit.md
Name: pio_shift_unit

Overview:
- Parametrised ISR/OSR pair with per-operation shift counters, programmable shift direction, autopush/autopull thresholds and blocking FIFO handshakes for one PIO state machine.
- Sits between the instruction executor (IN/OUT/PUSH/PULL strobes) and the RX/TX FIFOs.
- Replaces the fixed 32-bit shifters, which have no counters, no thresholds and no autopush/autopull.

Parameters:
- WIDTH, 32, ISR/OSR width in bits; power of two, 8..32
- CNT_W, $clog2(WIDTH)+1, width of the shift counts and thresholds

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- penable  input  1  clock-divider enable; state advances only when high
- in_dir, out_dir  input  1 each  shift direction: 0 = left (MSB first), 1 = right
- auto_push, auto_pull  input  1 each  enable autopush / autopull
- push_thresh, pull_thresh  input  CNT_W each  thresholds; 0 encodes WIDTH
- in_req  input  1  IN strobe
- in_count  input  CNT_W  bits to shift in; 0 encodes WIDTH
- in_data  input  WIDTH  source data for IN
- out_req  input  1  OUT strobe
- out_count  input  CNT_W  bits to shift out; 0 encodes WIDTH
- out_data  output  WIDTH  shifted-out bits, right-aligned, zero-extended
- push_req, push_iffull, push_block  input  1 each  explicit PUSH and its flags
- pull_req, pull_ifempty, pull_block  input  1 each  explicit PULL and its flags
- rx_data  output  WIDTH  data for the RX FIFO
- rx_push  output  1  RX write strobe
- rx_full  input  1  RX FIFO full
- tx_data  input  WIDTH  head of the TX FIFO
- tx_pull  output  1  TX read strobe
- tx_empty  input  1  TX FIFO empty
- isr, osr  output  WIDTH each  register contents
- isr_count, osr_count  output  CNT_W each  bits shifted, saturating at WIDTH
- stall  output  1  current operation not complete; executor must hold the PC
- done  output  1  current operation completed this cycle

Behaviour:
- Reset values: isr=0, isr_count=0, osr=0, osr_count=WIDTH (OSR empty), state IDLE; all strobes, stall and done low.
- Reset wins over every request, including in PUSH_WAIT.
- Request priority if several are high: in > out > push > pull. Executor drives at most one; the bench asserts this.
- Strobes (rx_push, tx_pull, done, stall) are combinational from current state and requests, and are qualified by penable.
- Register updates happen on the clk edge where penable=1.
- States: IDLE and PUSH_WAIT.
- IN, n = in_count (n=0 means WIDTH):
  - Left: isr <= (isr<<n) | in_data[n-1:0].
  - Right: isr <= (isr>>n) | (in_data[n-1:0] << (WIDTH-n)).
  - n=WIDTH: isr <= in_data.
  - isr_count <= min(isr_count+n, WIDTH).
- Autopush: if auto_push and the new count >= push_thresh:
  - rx_full=0: rx_push=1 with rx_data = new ISR value; isr and isr_count go to 0; done=1.
  - rx_full=1: store the shifted ISR, go to PUSH_WAIT, stall=1, done=0.
- PUSH_WAIT:
  - Requests are ignored; stall=1.
  - On the first penable cycle with rx_full=0: rx_push=1, rx_data=isr, isr and count cleared, done=1, return to IDLE.
- Without autopush, or below threshold, IN completes in one cycle with done=1.
- OUT, n = out_count:
  - Exhausted means auto_pull and osr_count >= pull_thresh.
  - Exhausted, tx_empty=1: stall=1, no change; retried every penable cycle while out_req is held.
  - Exhausted, tx_empty=0: tx_pull=1, the shift uses tx_data as the source, osr_count restarts at 0, done=1.
  - Left: out_data = src[WIDTH-1 -: n] and osr <= src<<n.
  - Right: out_data = src[n-1:0] and osr <= src>>n.
  - osr_count <= min(count+n, WIDTH).
- PUSH:
  - iffull=1 and isr_count < push_thresh: no-op, done=1.
  - rx_full=0: rx_push=1, rx_data=isr, ISR cleared, done=1.
  - rx_full=1 and block=1: stall=1, retried while push_req is held.
  - rx_full=1 and block=0: no rx_push, ISR and count still cleared, done=1.
- PULL:
  - ifempty=1 and osr_count < pull_thresh: no-op, done=1.
  - tx_empty=0: tx_pull=1, osr <= tx_data, osr_count <= 0, done=1.
  - tx_empty=1 and block=1: stall=1.
  - tx_empty=1 and block=0: OSR and count unchanged, done=1.
- penable=0: all strobes low and no register changes, including in PUSH_WAIT.
- Shift amounts are taken modulo nothing: n=WIDTH must never produce an out-of-range shift. Implementation special-cases n=WIDTH.

Test Plan:
- IN left, WIDTH=32: three IN of 8 bits with data 0xAA, 0xBB, 0xCC -> isr=0x00AABBCC, isr_count=24, no rx_push.
- Autopush with push_thresh=16, rx_full=0: two IN of 8 bits, 0x12 then 0x34 -> second cycle rx_push=1, rx_data=0x1234, isr=0, isr_count=0.
- Autopush with rx_full=1: same as above -> PUSH_WAIT with stall=1 for 3 cycles. Drop rx_full -> rx_push=1, rx_data=0x1234, done=1. Assert reset in PUSH_WAIT in a second run -> IDLE, no push.
- Autopull, right shift, pull_thresh=0 (WIDTH), tx_data=0xDEADBEEF, osr empty after reset: OUT of 8 -> tx_pull=1, out_data=0xEF, osr=0x00DEADBE, osr_count=8. Then with tx_empty=1, four more OUT of 8 -> fifth OUT stalls.
- Explicit PULL noblock with tx_empty=1 -> done=1, osr unchanged. PUSH iffull with isr_count=4 and thresh=8 -> no-op, done=1.
- penable toggling 1-in-3 during the autopull scenario -> identical results, each strobe exactly one clk wide, only on penable cycles.
